// File: rtl/din_debouncer_pkg.sv
// Shared types and helpers for the input-conditioning debouncer.
package din_debouncer_pkg;

    typedef enum logic [1:0] {
        DB_IDLE_LO = 2'd0,
        DB_PEND_HI = 2'd1,
        DB_IDLE_HI = 2'd2,
        DB_PEND_LO = 2'd3
    } debounce_state_t;

    // Width of the stability counter; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/din_debouncer_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] flops_r;

    // Shift the raw input through the chain; reset parks every flop at RESET_VAL.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            flops_r <= {STAGES{RESET_VAL}};
        end else begin
            flops_r <= {flops_r[STAGES-2:0], d};
        end
    end

    assign q = flops_r[STAGES-1];

endmodule

// File: rtl/din_debouncer.sv
// Debounced, synchronised copy of a raw 1-bit input with a bounce counter.
module din_debouncer
    import din_debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                din_async,
    input  logic                clr_glitch,
    output logic                dout,
    output logic                stable,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int                 CW        = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);
    localparam debounce_state_t    RESET_STATE = RESET_LEVEL ? DB_IDLE_HI : DB_IDLE_LO;

    logic              s_s;
    logic              glitch_s;
    debounce_state_t   state_r;
    logic [CW-1:0]     cnt_r;
    logic              dout_r;
    logic              stable_r;
    logic [GLITCH_W-1:0] glitch_r;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (din_async),
        .q      (s_s)
    );

    // A pending transition aborted because the synchronised level fell back.
    always_comb begin
        glitch_s = 1'b0;
        case (state_r)
            DB_PEND_HI: glitch_s = ~s_s;
            DB_PEND_LO: glitch_s = s_s;
            default:    glitch_s = 1'b0;
        endcase
    end

    // Debounce FSM: counter, accepted level and idle indication all registered here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= RESET_STATE;
            cnt_r    <= '0;
            dout_r   <= RESET_LEVEL;
            stable_r <= 1'b1;
        end else begin
            case (state_r)
                DB_IDLE_LO: begin
                    if (s_s) begin
                        state_r  <= DB_PEND_HI;
                        cnt_r    <= CNT_ONE;
                        stable_r <= 1'b0;
                    end else begin
                        cnt_r    <= '0;
                        stable_r <= 1'b1;
                    end
                end
                DB_PEND_HI: begin
                    if (!s_s) begin
                        state_r  <= DB_IDLE_LO;
                        cnt_r    <= '0;
                        stable_r <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r  <= DB_IDLE_HI;
                        cnt_r    <= '0;
                        dout_r   <= 1'b1;
                        stable_r <= 1'b1;
                    end else begin
                        cnt_r    <= cnt_r + CNT_ONE;
                        stable_r <= 1'b0;
                    end
                end
                DB_IDLE_HI: begin
                    if (!s_s) begin
                        state_r  <= DB_PEND_LO;
                        cnt_r    <= CNT_ONE;
                        stable_r <= 1'b0;
                    end else begin
                        cnt_r    <= '0;
                        stable_r <= 1'b1;
                    end
                end
                DB_PEND_LO: begin
                    if (s_s) begin
                        state_r  <= DB_IDLE_HI;
                        cnt_r    <= '0;
                        stable_r <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r  <= DB_IDLE_LO;
                        cnt_r    <= '0;
                        dout_r   <= 1'b0;
                        stable_r <= 1'b1;
                    end else begin
                        cnt_r    <= cnt_r + CNT_ONE;
                        stable_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= RESET_STATE;
                    cnt_r    <= '0;
                    dout_r   <= RESET_LEVEL;
                    stable_r <= 1'b1;
                end
            endcase
        end
    end

    // Saturating bounce counter; an explicit clear beats a simultaneous abort.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            glitch_r <= '0;
        end else if (clr_glitch) begin
            glitch_r <= '0;
        end else if (glitch_s && (glitch_r != GLITCH_MAX)) begin
            glitch_r <= glitch_r + GLITCH_ONE;
        end else begin
            glitch_r <= glitch_r;
        end
    end

    assign dout         = dout_r;
    assign stable       = stable_r;
    assign glitch_count = glitch_r;

endmodule

// File: tb/tb_din_debouncer.sv
// Directed bench for din_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=4.
module tb_din_debouncer;
    import din_debouncer_pkg::*;

    logic       clk;
    logic       resetn;
    logic       din_async;
    logic       clr_glitch;
    logic       dout;
    logic       stable;
    logic [3:0] glitch_count;

    int n_cmp;
    int n_fail;

    // Downstream edge-detector model fed by dout.
    logic dout_q;
    logic fall_pulse;
    int   fall_cnt = 0;

    din_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (1'b0),
        .GLITCH_W        (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .din_async    (din_async),
        .clr_glitch   (clr_glitch),
        .dout         (dout),
        .stable       (stable),
        .glitch_count (glitch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        dout_q     <= dout;
        fall_pulse <= dout_q & ~dout;
        if (dout_q === 1'b1 && dout === 1'b0) fall_cnt <= fall_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // din high for three captured edges then low; optional clear on the abort edge.
    task automatic bounce(input bit clr_on_abort);
        din_async = 1'b1;
        tick(); tick(); tick();
        din_async = 1'b0;
        tick(); tick();
        if (clr_on_abort) clr_glitch = 1'b1;
        tick();
        clr_glitch = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; din_async = 1'b1; clr_glitch = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout edge %0d: got %b want 0", e, dout); end
            n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL reset_stable edge %0d: got %b want 1", e, stable); end
            n_cmp++; if (glitch_count !== 4'd0) begin n_fail++; $display("FAIL reset_glitch edge %0d: got %0d want 0", e, glitch_count); end
        end
        resetn = 1'b1; din_async = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_clean_edge(input logic lvl);
        logic exp_dout;
        logic exp_stable;
        din_async = lvl;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_dout   = (e >= 5) ? lvl : ~lvl;
            exp_stable = (e >= 2 && e <= 4) ? 1'b0 : 1'b1;
            n_cmp++; if (dout !== exp_dout) begin n_fail++; $display("FAIL clean_%0b_dout edge %0d: got %b want %b", lvl, e, dout, exp_dout); end
            n_cmp++; if (stable !== exp_stable) begin n_fail++; $display("FAIL clean_%0b_stable edge %0d: got %b want %b", lvl, e, stable, exp_stable); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_gc;
        for (int i = 0; i < 20; i++) begin
            bounce(1'b0);
            exp_gc = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            n_cmp++; if (glitch_count !== exp_gc) begin n_fail++; $display("FAIL bounce_gc iter %0d: got %0d want %0d", i, glitch_count, exp_gc); end
            n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL bounce_dout iter %0d: got %b want 0", i, dout); end
            n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bounce_stable iter %0d: got %b want 1", i, stable); end
        end
    endtask

    task automatic test_clear_collision();
        clr_glitch = 1'b1;
        tick();
        clr_glitch = 1'b0;
        n_cmp++; if (glitch_count !== 4'd0) begin n_fail++; $display("FAIL clear_plain: got %0d want 0", glitch_count); end
        bounce(1'b0);
        n_cmp++; if (glitch_count !== 4'd1) begin n_fail++; $display("FAIL clear_pre: got %0d want 1", glitch_count); end
        bounce(1'b1);
        n_cmp++; if (glitch_count !== 4'd0) begin n_fail++; $display("FAIL clear_collision: got %0d want 0", glitch_count); end
    endtask

    task automatic test_reset_mid();
        bounce(1'b0);
        n_cmp++; if (glitch_count !== 4'd1) begin n_fail++; $display("FAIL rmid_pre_gc: got %0d want 1", glitch_count); end
        din_async = 1'b1;
        repeat (4) tick();
        n_cmp++; if (dut.cnt_r !== 2'd2) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 2", dut.cnt_r); end
        n_cmp++; if (dut.state_r !== DB_PEND_HI) begin n_fail++; $display("FAIL rmid_pend: got %0d want %0d", dut.state_r, DB_PEND_HI); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL rmid_dout: got %b want 0", dout); end
        n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL rmid_stable: got %b want 1", stable); end
        n_cmp++; if (glitch_count !== 4'd0) begin n_fail++; $display("FAIL rmid_gc: got %0d want 0", glitch_count); end
        n_cmp++; if (dut.state_r !== DB_IDLE_LO) begin n_fail++; $display("FAIL rmid_state: got %0d want %0d", dut.state_r, DB_IDLE_LO); end
        for (int e = 0; e <= 5; e++) begin
            tick();
            n_cmp++; if (dout !== (e >= 5)) begin n_fail++; $display("FAIL rmid_relatency edge %0d: got %b want %b", e, dout, (e >= 5)); end
        end
        n_cmp++; if (glitch_count !== 4'd0) begin n_fail++; $display("FAIL rmid_post_gc: got %0d want 0", glitch_count); end
    endtask

    task automatic test_handoff();
        int base;
        base = fall_cnt;
        din_async = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            n_cmp++; if (dout !== (e < 5)) begin n_fail++; $display("FAIL handoff_dout edge %0d: got %b want %b", e, dout, (e < 5)); end
            n_cmp++; if (fall_pulse !== (e == 6)) begin n_fail++; $display("FAIL handoff_pulse edge %0d: got %b want %b", e, fall_pulse, (e == 6)); end
        end
        n_cmp++; if (fall_cnt - base !== 1) begin n_fail++; $display("FAIL handoff_count: got %0d want 1", fall_cnt - base); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_clean_edge(1'b1);
        test_clean_edge(1'b0);
        test_bounce();
        test_clear_collision();
        test_reset_mid();
        test_handoff();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
